instr_loader: RTL and testbench

//  Host-side driver of the npu instruction memory port (64x20 SRAM; CEB/WEB/A/D = start_instr_b/read_or_write/

---
 rtl/instr_loader_if.sv | 31 +++
 rtl/instr_loader.sv | 195 +++++++++++++++++++
 tb/tb_instr_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Instruction-loader bus bundle.
//   Host stream : in_valid, in_data (host -> loader), in_ready (loader -> host)
//   Memory port : start_instr_b, read_or_write, addr_count, instr_in (loader -> npu)
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_data is only meaningful while in_valid is high. The host may raise
// in_valid at any time. in_valid does not depend on in_ready.
// Modports:
//   master : the loader (drives in_ready and the memory port)
//   slave  : the environment (host source plus npu memory)
interface instr_loader_if #(
  parameter int INSTR_W = 20,
  parameter int ADDR_W  = 6
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;
  logic               start_instr_b;
  logic               read_or_write;
  logic [ADDR_W-1:0]  addr_count;
  logic [INSTR_W-1:0] instr_in;

  modport master (
    input  in_valid, in_data,
    output in_ready, start_instr_b, read_or_write, addr_count, instr_in
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, start_instr_b, read_or_write, addr_count, instr_in
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: host-side driver of the npu instruction memory port.
// It streams host words into addresses 0..len-1. It can then append the
// 20'hFFFFF terminator. After that it holds the port idle (ARMED) or in read
// mode (RUN), so that the npu sequencer executes the program.
// Ports:
//   clk_in, rst   clock; asynchronous active-high reset
//   load_start    pulse, begin loading load_len words
//   load_len      word count, 1..DEPTH-AUTO_TERM
//   run_start     pulse, start execution
//   run_stop      pulse, end execution
//   port          instr_loader_if.master (host stream + memory port)
//   busy          state is LOAD, TERM or RUN
//   loaded        a valid program is resident
//   load_done     1-cycle pulse in the cycle after the final write
//   err           1-cycle pulse on a rejected command
//   dbg_state     current FSM state (encoding of state_t)
// Every output is a register. The comb block computes the value for the next
// cycle, and the output registers then line up with the state register.
module instr_loader #(
  parameter int  DEPTH     = 64,
  parameter int  INSTR_W   = 20,
  parameter bit  AUTO_TERM = 1'b1,
  parameter int  RUN_MAX   = 0,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             run_start,
  input  logic             run_stop,
  instr_loader_if.master   port,
  output logic             busy,
  output logic             loaded,
  output logic             load_done,
  output logic             err,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TERM  = 3'd2,
    ST_ARMED = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(DEPTH - (AUTO_TERM ? 1 : 0));
  localparam logic [INSTR_W-1:0] TERM_WORD = '1;
  localparam logic [15:0]        CNT_LIMIT = 16'(RUN_MAX - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               ceb_q, ceb_d, web_q, web_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic               in_ready_q, in_ready_d;
  logic               loaded_q, loaded_d;
  logic               busy_q, busy_d;
  // final_q is high while the final write is on the port. load_done follows it by one cycle.
  logic               final_q, final_d;
  logic               done_q, err_q, err_d;
  logic               len_ok, last_word;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ceb_d    = 1'b1;
    web_d    = 1'b1;
    addr_d   = '0;
    data_d   = '0;
    loaded_d = loaded_q;
    final_d  = 1'b0;
    err_d    = 1'b0;
    len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
    last_word = ((LEN_W'(wptr_q) + LEN_W'(1)) == len_q);

    case (state_q)
      ST_IDLE, ST_ARMED: begin
        if (load_start && len_ok) begin
          len_d    = load_len;
          wptr_d   = '0;
          loaded_d = 1'b0;
          state_d  = ST_LOAD;
          err_d    = run_start;          // load wins over a simultaneous run
        end else begin
          if (load_start) err_d = 1'b1;  // out-of-range length
          if (run_start) begin
            if (state_q == ST_ARMED && loaded_q) begin
              if (!run_stop) begin       // start together with stop: stop wins
                state_d = ST_RUN;
                cnt_d   = '0;
                ceb_d   = 1'b0;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_LOAD: begin
        if (load_start || run_start) err_d = 1'b1;
        if (port.in_valid && in_ready_q) begin
          ceb_d  = 1'b0;
          web_d  = 1'b0;
          addr_d = wptr_q;
          data_d = port.in_data;
          wptr_d = wptr_q + ADDR_W'(1);
          if (last_word) begin
            if (AUTO_TERM) begin
              state_d = ST_TERM;
            end else begin
              state_d  = ST_ARMED;
              loaded_d = 1'b1;
              final_d  = 1'b1;
            end
          end
        end
      end
      ST_TERM: begin
        if (load_start || run_start) err_d = 1'b1;
        // len never exceeds DEPTH-1 here, so the truncation cannot wrap.
        ceb_d    = 1'b0;
        web_d    = 1'b0;
        addr_d   = ADDR_W'(len_q);
        data_d   = TERM_WORD;
        state_d  = ST_ARMED;
        loaded_d = 1'b1;
        final_d  = 1'b1;
      end
      ST_RUN: begin
        if (load_start || run_start) err_d = 1'b1;
        if (run_stop || (RUN_MAX != 0 && cnt_q == CNT_LIMIT)) begin
          state_d = ST_ARMED;
        end else begin
          ceb_d = 1'b0;
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_TERM) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ceb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      loaded_q   <= 1'b0;
      busy_q     <= 1'b0;
      final_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ceb_q      <= ceb_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      loaded_q   <= loaded_d;
      busy_q     <= busy_d;
      final_q    <= final_d;
      done_q     <= final_q;
      err_q      <= err_d;
    end
  end

  assign port.start_instr_b = ceb_q;
  assign port.read_or_write = web_q;
  assign port.addr_count    = addr_q;
  assign port.instr_in      = data_q;
  assign port.in_ready      = in_ready_q;
  assign busy               = busy_q;
  assign loaded             = loaded_q;
  assign load_done          = done_q;
  assign err                = err_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  localparam int W = 26;  // {addr[5:0], data[19:0]}
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_ARMED = 3'd3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0, run_start = 1'b0, run_stop = 1'b0;
  logic [6:0] load_len = '0;
  logic       busy, loaded, load_done, err;
  logic [2:0] dbg_state;
  logic       busy5, loaded5, load_done5, err5;
  logic [2:0] dbg_state5;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int nd;
  logic [W-1:0] exp_q[$];
  int wr_cyc[$];

  instr_loader_if #(.INSTR_W(20), .ADDR_W(6)) bus ();
  instr_loader_if #(.INSTR_W(20), .ADDR_W(6)) bus5 ();
  assign bus5.in_valid = bus.in_valid;
  assign bus5.in_data  = bus.in_data;

  instr_loader #(.RUN_MAX(0)) dut (
    .clk_in(clk_in), .rst(rst), .load_start(load_start), .load_len(load_len),
    .run_start(run_start), .run_stop(run_stop), .port(bus.master),
    .busy(busy), .loaded(loaded), .load_done(load_done), .err(err), .dbg_state(dbg_state)
  );

  instr_loader #(.RUN_MAX(5)) dut5 (
    .clk_in(clk_in), .rst(rst), .load_start(load_start), .load_len(load_len),
    .run_start(run_start), .run_stop(run_stop), .port(bus5.master),
    .busy(busy5), .loaded(loaded5), .load_done(load_done5), .err(err5), .dbg_state(dbg_state5)
  );

  // clock / reset block
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // scoreboard: every memory write on the main instance is matched in order
  always @(negedge clk_in) begin
    if (!rst && !bus.start_instr_b && !bus.read_or_write) begin
      if (exp_q.size() == 0) check("wr_unexpected", {bus.addr_count, bus.instr_in}, '1);
      else check("wr", 32'({bus.addr_count, bus.instr_in}), 32'(exp_q.pop_front()));
      wr_cyc.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_load(input logic [6:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!load_done && n < 20) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic check_idle_port(input string tag);
    check({tag, "_ceb"}, 32'(bus.start_instr_b), 32'd1);
    check({tag, "_web"}, 32'(bus.read_or_write), 32'd1);
    check({tag, "_addr"}, 32'(bus.addr_count), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // 1. reset held while inputs toggle
    for (int i = 0; i < 5; i++) begin
      load_start   = 1'($urandom_range(0, 1));
      run_start    = 1'($urandom_range(0, 1));
      run_stop     = 1'($urandom_range(0, 1));
      load_len     = 7'($urandom_range(0, 127));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 20'($urandom_range(0, 20'hFFFFF));
      tick();
      check_idle_port("rst");
      check("rst_loaded", 32'(loaded), 32'd0);
    end
    load_start = 1'b0; run_start = 1'b0; run_stop = 1'b0; bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(bus.in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // 4. rejected commands in IDLE
    start_load(7'd0);
    check("len0_err", 32'(err), 32'd1);
    check("len0_state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    check("err_pulse", 32'(err), 32'd0);
    start_load(7'd64);
    check("len64_err", 32'(err), 32'd1);
    check("len64_state", 32'(dbg_state), 32'(S_IDLE));
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("run_unloaded_err", 32'(err), 32'd1);
    check("run_unloaded_state", 32'(dbg_state), 32'(S_IDLE));

    // 2. three back-to-back words plus terminator
    exp_q.push_back({6'd0, 20'hA1111});
    exp_q.push_back({6'd1, 20'hB2222});
    exp_q.push_back({6'd2, 20'hC3333});
    exp_q.push_back({6'd3, 20'hFFFFF});
    wr_cyc.delete();
    start_load(7'd3);
    check("load_ready", 32'(bus.in_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data = 20'hA1111; tick();
    bus.in_data = 20'hB2222; tick();
    bus.in_data = 20'hC3333; tick();
    bus.in_valid = 1'b0;
    check("last_ready_low", 32'(bus.in_ready), 32'd0);
    wait_done(nd);
    check("done_latency", 32'(nd), 32'd2);
    check("loaded_after", 32'(loaded), 32'd1);
    check("armed_state", 32'(dbg_state), 32'(S_ARMED));
    check("t2_wr_count", 32'(wr_cyc.size()), 32'd4);
    if (wr_cyc.size() == 4) check("t2_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("done_pulse", 32'(load_done), 32'd0);

    // 3. two words with 2-cycle valid gaps; garbage data while invalid
    exp_q.push_back({6'd0, 20'h12345});
    exp_q.push_back({6'd1, 20'h6789A});
    exp_q.push_back({6'd2, 20'hFFFFF});
    wr_cyc.delete();
    start_load(7'd2);
    check("reload_clears_loaded", 32'(loaded), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 20'h12345; tick();
    bus.in_valid = 1'b0; bus.in_data = 20'hDEAD0; tick();
    bus.in_data = 20'hBEEF0; tick();
    bus.in_valid = 1'b1; bus.in_data = 20'h6789A; tick();
    bus.in_valid = 1'b0;
    wait_done(nd);
    check("t3_wr_count", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) check("t3_bubble_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_loaded", 32'(loaded), 32'd1);

    // simultaneous run_start + run_stop in ARMED: stop wins, no error
    run_start = 1'b1; run_stop = 1'b1;
    tick();
    run_start = 1'b0; run_stop = 1'b0;
    check("startstop_state", 32'(dbg_state), 32'(S_ARMED));
    check("startstop_err", 32'(err), 32'd0);

    // 5. run: stop after 10 cycles on dut, auto-exit after 5 on dut5
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check("run_ceb", 32'(bus.start_instr_b), 32'd0);
      check("run_web", 32'(bus.read_or_write), 32'd1);
      check("run_addr", 32'(bus.addr_count), 32'd0);
      check("run5_ceb", 32'(bus5.start_instr_b), 32'(i > 5));
      if (i == 10) run_stop = 1'b1;
      tick();
    end
    run_stop = 1'b0;
    check_idle_port("stop");
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_loaded", 32'(loaded), 32'd1);
    check("stop_err", 32'(err), 32'd0);
    check("run5_loaded", 32'(loaded5), 32'd1);

    // 6. reset during LOAD after 1 of 4 words; a run_start in LOAD is rejected
    exp_q.push_back({6'd0, 20'h0F0F0});
    start_load(7'd4);
    run_start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 20'h0F0F0;
    tick();
    run_start = 1'b0; bus.in_valid = 1'b0;
    check("load_run_err", 32'(err), 32'd1);
    check("load_run_state", 32'(dbg_state), 32'(S_LOAD));
    @(negedge clk_in);
    #1 rst = 1'b1;
    #1;
    check_idle_port("midrst");
    check("midrst_loaded", 32'(loaded), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back({6'd0, 20'h55AA5});
    exp_q.push_back({6'd1, 20'hFFFFF});
    start_load(7'd1);
    bus.in_valid = 1'b1; bus.in_data = 20'h55AA5; tick();
    bus.in_valid = 1'b0;
    wait_done(nd);
    check("reload_loaded", 32'(loaded), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
